pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central hazard and sequencing controller for the five-stage PA-RISC pipeline. It drives the load enables and clears of the PC and IF/ID registers, selects NOP injection into ID/EX, and generates forwarding selects for the ID/EX operand inputs. It also provides a drain-and-halt handshake for debug/freeze requests. It keeps saturating stall and flush counters for performance visibility.

## Interface
Parameters:
- CNT_W, 16, width of the STALL_CNT and FLUSH_CNT performance counters
- DRAIN_CYCLES, 3, number of NOP-injection cycles needed to empty EX, MEM and WB

Ports:
- Clk  input  1  clock; all state changes on the rising edge
- Rst  input  1  reset, synchronous, active-high
- ID_RA, ID_RB  input  5  source register numbers of the instruction in ID
- ID_USE_RA, ID_USE_RB  input  1  ID instruction actually reads RA / RB
- EX_RD  input  5  destination register of the EX instruction
- EX_RF_LE, EX_L  input  1  EX instruction writes the RF / is a load
- MEM_RD  input  5  MEM destination; MEM_RF_LE  input  1  MEM writes RF
- WB_RD  input  5  WB destination; WB_RF_LE  input  1  WB writes RF
- EX_BR_TAKEN  input  1  branch in EX resolved taken (target valid this cycle)
- HOLD_REQ  input  1  freeze request (level)
- PC_LE  output  1  load enable for the PC front and back registers
- IF_ID_LE, IF_ID_CLR  output  1  IF/ID load enable / clear
- NOP_SEL  output  1  control mux selects the all-zero NOP into ID/EX
- FWD_A, FWD_B  output  2  operand source: 00 RF, 01 EX result, 10 MEM output, 11 WB value
- HOLD_ACK  output  1  pipeline drained and frozen
- STATE  output  2  00 RUN, 01 DRAIN, 10 HALTED
- STALL_CNT, FLUSH_CNT  output  CNT_W  saturating event counters

## Operation
- Register 0 is hardwired zero. A destination of 0 never matches, never forwards and never stalls.
- Forwarding is combinational and active in every state. For operand X with ID_USE_X=1, the first match in priority order wins:
  - EX_RF_LE && EX_RD==ID_X && !EX_L → 01
  - MEM_RF_LE && MEM_RD==ID_X → 10
  - WB_RF_LE && WB_RD==ID_X → 11
  - otherwise 00.
- A load-use hazard exists when EX_L && EX_RF_LE && EX_RD!=0 and EX_RD equals a used ID source. In that case FWD for that operand is 00 (the value is not yet valid).
- State RUN:
  - No hazard: PC_LE=1, IF_ID_LE=1, IF_ID_CLR=0, NOP_SEL=0.
  - Load-use hazard: PC_LE=0, IF_ID_LE=0, NOP_SEL=1 for that cycle. STALL_CNT increments. The next cycle the load sits in MEM and forwards with select 10.
  - EX_BR_TAKEN: PC_LE=1, IF_ID_LE=1, IF_ID_CLR=1. The delay-slot instruction in ID proceeds; the wrong-path instruction being fetched is cleared. FLUSH_CNT increments.
  - EX_BR_TAKEN overrides load-use if both are present. A branch is never a load; the combination is illegal, but the behaviour is defined as above.
  - HOLD_REQ=1 && !EX_BR_TAKEN → DRAIN at the next edge, with the drain counter loaded with DRAIN_CYCLES-1. While EX_BR_TAKEN=1, entry is deferred one cycle.
- State DRAIN: PC_LE=0, IF_ID_LE=0, NOP_SEL=1, IF_ID_CLR=0. The counter decrements each cycle; at 0 → HALTED. HOLD_REQ dropping during DRAIN does not abort the drain; the block completes it and then returns to RUN via HALTED.
- State HALTED: the same freeze outputs plus HOLD_ACK=1. HOLD_REQ=0 → RUN at the next edge.
- Counters increment by 1 and saturate at all-ones. They never wrap.

## Timing
- All pipeline-control and FWD outputs are combinational from the current inputs and registered state, so they take effect at the same edge as the pipeline registers.
- STATE, HOLD_ACK and the counters are registered and update on the rising edge of Clk.
- While Rst=1: PC_LE=0, IF_ID_LE=0, IF_ID_CLR=1, NOP_SEL=1, FWD_A=FWD_B=00, HOLD_ACK=0.
- After the reset edge: STATE=RUN, drain counter=0, STALL_CNT=FLUSH_CNT=0.
- Rst mid-DRAIN or mid-HALTED returns to RUN at that edge and drops HOLD_ACK.
- HOLD_REQ handshake:
  - RUN→DRAIN is 1 edge after HOLD_REQ is seen.
  - HOLD_ACK rises DRAIN_CYCLES edges after entering DRAIN.
  - HOLD_ACK falls on the edge where HALTED→RUN.
- Load-use stall costs exactly 1 cycle. A taken branch costs 1 flushed slot.

## Test plan
- Forwarding priority: EX_RD=MEM_RD=WB_RD=5, all RF_LE=1, EX_L=0, ID_RA=5, ID_USE_RA=1 → FWD_A=01. Drop EX_RF_LE → 10. Drop MEM_RF_LE → 11. Set ID_RA=0 → 00.
- Load-use: EX_L=1, EX_RF_LE=1, EX_RD=7, ID_RB=7, ID_USE_RB=1 → PC_LE=0, IF_ID_LE=0, NOP_SEL=1, FWD_B=00, STALL_CNT 0→1. Next cycle (MEM_RD=7, MEM_RF_LE=1, EX clear) → FWD_B=10, no stall.
- Branch flush: EX_BR_TAKEN=1 with no hazard → IF_ID_CLR=1, PC_LE=1, FLUSH_CNT increments. Same with a load-use hazard presented simultaneously → still flush, STALL_CNT unchanged.
- Drain/halt: assert HOLD_REQ in RUN → STATE=01 next edge, freeze outputs for 3 cycles, then STATE=10 and HOLD_ACK=1. Deassert HOLD_REQ → STATE=00 and HOLD_ACK=0 next edge.
- Deferral and reset: HOLD_REQ and EX_BR_TAKEN together → remain RUN one cycle, then DRAIN. Rst during HALTED → RUN, HOLD_ACK=0, counters 0, reset-cycle outputs as specified.
- Saturation: with CNT_W=4, force 20 consecutive load-use stalls → STALL_CNT holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard controller bus.
// The pipeline side (master) presents the ID/EX/MEM/WB register fields,
// the branch outcome and the freeze request. The controller side (slave)
// returns the register enables, NOP injection, forwarding selects,
// handshake status and performance counters.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_RA;
  logic [4:0]       ID_RB;
  logic             ID_USE_RA;
  logic             ID_USE_RB;
  logic [4:0]       EX_RD;
  logic             EX_RF_LE;
  logic             EX_L;
  logic [4:0]       MEM_RD;
  logic             MEM_RF_LE;
  logic [4:0]       WB_RD;
  logic             WB_RF_LE;
  logic             EX_BR_TAKEN;
  logic             HOLD_REQ;
  logic             PC_LE;
  logic             IF_ID_LE;
  logic             IF_ID_CLR;
  logic             NOP_SEL;
  logic [1:0]       FWD_A;
  logic [1:0]       FWD_B;
  logic             HOLD_ACK;
  logic [1:0]       STATE;
  logic [CNT_W-1:0] STALL_CNT;
  logic [CNT_W-1:0] FLUSH_CNT;

  modport master (
    output ID_RA, ID_RB, ID_USE_RA, ID_USE_RB,
    output EX_RD, EX_RF_LE, EX_L, MEM_RD, MEM_RF_LE, WB_RD, WB_RF_LE,
    output EX_BR_TAKEN, HOLD_REQ,
    input  PC_LE, IF_ID_LE, IF_ID_CLR, NOP_SEL, FWD_A, FWD_B,
    input  HOLD_ACK, STATE, STALL_CNT, FLUSH_CNT
  );

  modport slave (
    input  ID_RA, ID_RB, ID_USE_RA, ID_USE_RB,
    input  EX_RD, EX_RF_LE, EX_L, MEM_RD, MEM_RF_LE, WB_RD, WB_RF_LE,
    input  EX_BR_TAKEN, HOLD_REQ,
    output PC_LE, IF_ID_LE, IF_ID_CLR, NOP_SEL, FWD_A, FWD_B,
    output HOLD_ACK, STATE, STALL_CNT, FLUSH_CNT
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline.
// Forwarding selects and pipeline register controls are combinational so
// they act on the same edge as the pipeline registers; the RUN/DRAIN/HALTED
// sequencer, HOLD_ACK and the saturating stall/flush counters are registered.
module pipeline_hazard_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input logic                  Clk,
  input logic                  Rst,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [DW-1:0]     drain_cnt_r;
  logic [DW-1:0]     drain_cnt_nxt_s;
  logic              hold_ack_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;
  logic              load_use_s;
  logic              stall_inc_s;
  logic              flush_inc_s;
  logic [1:0]        fwd_a_s;
  logic [1:0]        fwd_b_s;
  logic              pc_le_s;
  logic              if_id_le_s;
  logic              if_id_clr_s;
  logic              nop_sel_s;

  // Operand source for one ID read port. A load still in EX has no valid
  // result yet, so a match against it selects the RF (the stall covers it).
  function automatic logic [1:0] fwd_sel(
    input logic       use_src,
    input logic [4:0] src,
    input logic       ex_le,
    input logic       ex_l,
    input logic [4:0] ex_rd,
    input logic       mem_le,
    input logic [4:0] mem_rd,
    input logic       wb_le,
    input logic [4:0] wb_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (!use_src || (src == 5'd0)) begin
      sel = 2'b00;
    end else if (ex_le && (ex_rd == src) && ex_l) begin
      sel = 2'b00;
    end else if (ex_le && (ex_rd == src)) begin
      sel = 2'b01;
    end else if (mem_le && (mem_rd == src)) begin
      sel = 2'b10;
    end else if (wb_le && (wb_rd == src)) begin
      sel = 2'b11;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard detection and forwarding selects from the current stage fields.
  always_comb begin
    load_use_s = 1'b0;
    if (bus.EX_L && bus.EX_RF_LE && (bus.EX_RD != 5'd0)) begin
      load_use_s = (bus.ID_USE_RA && (bus.EX_RD == bus.ID_RA)) ||
                   (bus.ID_USE_RB && (bus.EX_RD == bus.ID_RB));
    end else begin
      load_use_s = 1'b0;
    end
    fwd_a_s = fwd_sel(bus.ID_USE_RA, bus.ID_RA, bus.EX_RF_LE, bus.EX_L, bus.EX_RD,
                      bus.MEM_RF_LE, bus.MEM_RD, bus.WB_RF_LE, bus.WB_RD);
    fwd_b_s = fwd_sel(bus.ID_USE_RB, bus.ID_RB, bus.EX_RF_LE, bus.EX_L, bus.EX_RD,
                      bus.MEM_RF_LE, bus.MEM_RD, bus.WB_RF_LE, bus.WB_RD);
  end

  // Sequencer next state: enter DRAIN on a hold request unless a branch is
  // resolving, count the drain down, and leave HALTED once the request drops.
  always_comb begin
    state_nxt_s     = state_r;
    drain_cnt_nxt_s = drain_cnt_r;
    case (state_r)
      ST_RUN: begin
        if (bus.HOLD_REQ && !bus.EX_BR_TAKEN) begin
          state_nxt_s     = ST_DRAIN;
          drain_cnt_nxt_s = DRAIN_LOAD;
        end else begin
          state_nxt_s     = ST_RUN;
          drain_cnt_nxt_s = drain_cnt_r;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == {DW{1'b0}}) begin
          state_nxt_s     = ST_HALTED;
          drain_cnt_nxt_s = {DW{1'b0}};
        end else begin
          state_nxt_s     = ST_DRAIN;
          drain_cnt_nxt_s = drain_cnt_r - DW'(1);
        end
      end
      ST_HALTED: begin
        if (!bus.HOLD_REQ) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALTED;
        end
      end
      default: begin
        state_nxt_s     = ST_RUN;
        drain_cnt_nxt_s = {DW{1'b0}};
      end
    endcase
  end

  // Pipeline register controls; reset and non-RUN states freeze the front end.
  always_comb begin
    pc_le_s     = 1'b0;
    if_id_le_s  = 1'b0;
    if_id_clr_s = 1'b0;
    nop_sel_s   = 1'b1;
    if (Rst) begin
      if_id_clr_s = 1'b1;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (bus.EX_BR_TAKEN) begin
            pc_le_s     = 1'b1;
            if_id_le_s  = 1'b1;
            if_id_clr_s = 1'b1;
            nop_sel_s   = 1'b0;
          end else if (load_use_s) begin
            pc_le_s    = 1'b0;
            if_id_le_s = 1'b0;
            nop_sel_s  = 1'b1;
          end else begin
            pc_le_s    = 1'b1;
            if_id_le_s = 1'b1;
            nop_sel_s  = 1'b0;
          end
        end
        default: begin
          pc_le_s    = 1'b0;
          if_id_le_s = 1'b0;
          nop_sel_s  = 1'b1;
        end
      endcase
    end
  end

  assign stall_inc_s = (state_r == ST_RUN) && !bus.EX_BR_TAKEN && load_use_s;
  assign flush_inc_s = (state_r == ST_RUN) && bus.EX_BR_TAKEN;

  // Sequencer state, drain counter and the registered hold acknowledge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r     <= ST_RUN;
      drain_cnt_r <= {DW{1'b0}};
      hold_ack_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
      hold_ack_r  <= (state_nxt_s == ST_HALTED);
    end
  end

  // Saturating performance counters for stalls and branch flushes.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_inc_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (flush_inc_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  assign bus.PC_LE     = pc_le_s;
  assign bus.IF_ID_LE  = if_id_le_s;
  assign bus.IF_ID_CLR = if_id_clr_s;
  assign bus.NOP_SEL   = nop_sel_s;
  assign bus.FWD_A     = Rst ? 2'b00 : fwd_a_s;
  assign bus.FWD_B     = Rst ? 2'b00 : fwd_b_s;
  assign bus.HOLD_ACK  = hold_ack_r;
  assign bus.STATE     = state_r;
  assign bus.STALL_CNT = stall_cnt_r;
  assign bus.FLUSH_CNT = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: forwarding priority, load-use
// stall, branch flush, drain/halt handshake, deferral, reset and saturation.
module tb_pipeline_hazard_ctrl;

  logic Clk;
  logic Rst;
  int   checks;
  int   errors;

  pipeline_hazard_ctrl_if #(.CNT_W(4)) bus ();

  pipeline_hazard_ctrl #(.CNT_W(4), .DRAIN_CYCLES(3)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Step one clock; leave 1 time unit after the edge before anything else.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.ID_RA = 5'd0; bus.ID_RB = 5'd0; bus.ID_USE_RA = 1'b0; bus.ID_USE_RB = 1'b0;
    bus.EX_RD = 5'd0; bus.EX_RF_LE = 1'b0; bus.EX_L = 1'b0;
    bus.MEM_RD = 5'd0; bus.MEM_RF_LE = 1'b0; bus.WB_RD = 5'd0; bus.WB_RF_LE = 1'b0;
    bus.EX_BR_TAKEN = 1'b0; bus.HOLD_REQ = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    idle();
    bus.EX_RD = 5'd5; bus.EX_RF_LE = 1'b1; bus.ID_RA = 5'd5; bus.ID_USE_RA = 1'b1;
    step(); step();
    checks++; if (bus.PC_LE !== 1'b0) begin errors++; $display("FAIL rst_pc_le got %0b want 0", bus.PC_LE); end
    checks++; if (bus.IF_ID_LE !== 1'b0) begin errors++; $display("FAIL rst_if_id_le got %0b want 0", bus.IF_ID_LE); end
    checks++; if (bus.IF_ID_CLR !== 1'b1) begin errors++; $display("FAIL rst_if_id_clr got %0b want 1", bus.IF_ID_CLR); end
    checks++; if (bus.NOP_SEL !== 1'b1) begin errors++; $display("FAIL rst_nop_sel got %0b want 1", bus.NOP_SEL); end
    checks++; if (bus.FWD_A !== 2'b00) begin errors++; $display("FAIL rst_fwd_a got %0b want 00", bus.FWD_A); end
    checks++; if (bus.HOLD_ACK !== 1'b0) begin errors++; $display("FAIL rst_hold_ack got %0b want 0", bus.HOLD_ACK); end
    checks++; if (bus.STATE !== 2'b00) begin errors++; $display("FAIL rst_state got %0b want 00", bus.STATE); end
    checks++; if (bus.STALL_CNT !== 4'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d want 0", bus.STALL_CNT); end
    checks++; if (bus.FLUSH_CNT !== 4'd0) begin errors++; $display("FAIL rst_flush_cnt got %0d want 0", bus.FLUSH_CNT); end
    Rst = 1'b0;
    idle();
    #1;
    checks++; if (bus.PC_LE !== 1'b1) begin errors++; $display("FAIL run_pc_le got %0b want 1", bus.PC_LE); end
    checks++; if (bus.NOP_SEL !== 1'b0) begin errors++; $display("FAIL run_nop_sel got %0b want 0", bus.NOP_SEL); end
  endtask

  task automatic test_forwarding();
    idle();
    bus.EX_RD = 5'd5; bus.MEM_RD = 5'd5; bus.WB_RD = 5'd5;
    bus.EX_RF_LE = 1'b1; bus.MEM_RF_LE = 1'b1; bus.WB_RF_LE = 1'b1;
    bus.ID_RA = 5'd5; bus.ID_USE_RA = 1'b1; bus.ID_RB = 5'd5; bus.ID_USE_RB = 1'b0;
    #1;
    checks++; if (bus.FWD_A !== 2'b01) begin errors++; $display("FAIL fwd_ex got %0b want 01", bus.FWD_A); end
    checks++; if (bus.FWD_B !== 2'b00) begin errors++; $display("FAIL fwd_unused_b got %0b want 00", bus.FWD_B); end
    checks++; if (bus.PC_LE !== 1'b1) begin errors++; $display("FAIL fwd_no_stall got %0b want 1", bus.PC_LE); end
    bus.EX_RF_LE = 1'b0; #1;
    checks++; if (bus.FWD_A !== 2'b10) begin errors++; $display("FAIL fwd_mem got %0b want 10", bus.FWD_A); end
    bus.MEM_RF_LE = 1'b0; #1;
    checks++; if (bus.FWD_A !== 2'b11) begin errors++; $display("FAIL fwd_wb got %0b want 11", bus.FWD_A); end
    bus.ID_RA = 5'd0; bus.EX_RD = 5'd0; bus.MEM_RD = 5'd0; bus.WB_RD = 5'd0;
    bus.EX_RF_LE = 1'b1; bus.MEM_RF_LE = 1'b1; #1;
    checks++; if (bus.FWD_A !== 2'b00) begin errors++; $display("FAIL fwd_r0 got %0b want 00", bus.FWD_A); end
    bus.EX_L = 1'b1; #1;
    checks++; if (bus.NOP_SEL !== 1'b0) begin errors++; $display("FAIL r0_load_no_stall got %0b want 0", bus.NOP_SEL); end
    step();
    checks++; if (bus.STALL_CNT !== 4'd0) begin errors++; $display("FAIL r0_stall_cnt got %0d want 0", bus.STALL_CNT); end
  endtask

  task automatic test_load_use();
    idle();
    bus.EX_L = 1'b1; bus.EX_RF_LE = 1'b1; bus.EX_RD = 5'd7;
    bus.ID_RB = 5'd7; bus.ID_USE_RB = 1'b1;
    #1;
    checks++; if (bus.PC_LE !== 1'b0) begin errors++; $display("FAIL lu_pc_le got %0b want 0", bus.PC_LE); end
    checks++; if (bus.IF_ID_LE !== 1'b0) begin errors++; $display("FAIL lu_if_id_le got %0b want 0", bus.IF_ID_LE); end
    checks++; if (bus.NOP_SEL !== 1'b1) begin errors++; $display("FAIL lu_nop_sel got %0b want 1", bus.NOP_SEL); end
    checks++; if (bus.FWD_B !== 2'b00) begin errors++; $display("FAIL lu_fwd_b got %0b want 00", bus.FWD_B); end
    step();
    checks++; if (bus.STALL_CNT !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d want 1", bus.STALL_CNT); end
    bus.EX_L = 1'b0; bus.EX_RF_LE = 1'b0; bus.EX_RD = 5'd0;
    bus.MEM_RD = 5'd7; bus.MEM_RF_LE = 1'b1;
    #1;
    checks++; if (bus.FWD_B !== 2'b10) begin errors++; $display("FAIL lu_next_fwd_b got %0b want 10", bus.FWD_B); end
    checks++; if (bus.PC_LE !== 1'b1) begin errors++; $display("FAIL lu_next_pc_le got %0b want 1", bus.PC_LE); end
    checks++; if (bus.NOP_SEL !== 1'b0) begin errors++; $display("FAIL lu_next_nop got %0b want 0", bus.NOP_SEL); end
    step();
    checks++; if (bus.STALL_CNT !== 4'd1) begin errors++; $display("FAIL lu_once_cnt got %0d want 1", bus.STALL_CNT); end
  endtask

  task automatic test_branch();
    idle();
    bus.EX_BR_TAKEN = 1'b1;
    #1;
    checks++; if (bus.IF_ID_CLR !== 1'b1) begin errors++; $display("FAIL br_clr got %0b want 1", bus.IF_ID_CLR); end
    checks++; if (bus.PC_LE !== 1'b1) begin errors++; $display("FAIL br_pc_le got %0b want 1", bus.PC_LE); end
    checks++; if (bus.IF_ID_LE !== 1'b1) begin errors++; $display("FAIL br_if_id_le got %0b want 1", bus.IF_ID_LE); end
    step();
    checks++; if (bus.FLUSH_CNT !== 4'd1) begin errors++; $display("FAIL br_flush_cnt got %0d want 1", bus.FLUSH_CNT); end
    bus.EX_L = 1'b1; bus.EX_RF_LE = 1'b1; bus.EX_RD = 5'd9; bus.ID_RA = 5'd9; bus.ID_USE_RA = 1'b1;
    #1;
    checks++; if (bus.IF_ID_CLR !== 1'b1) begin errors++; $display("FAIL brlu_clr got %0b want 1", bus.IF_ID_CLR); end
    checks++; if (bus.NOP_SEL !== 1'b0) begin errors++; $display("FAIL brlu_nop got %0b want 0", bus.NOP_SEL); end
    step();
    checks++; if (bus.FLUSH_CNT !== 4'd2) begin errors++; $display("FAIL brlu_flush_cnt got %0d want 2", bus.FLUSH_CNT); end
    checks++; if (bus.STALL_CNT !== 4'd1) begin errors++; $display("FAIL brlu_stall_cnt got %0d want 1", bus.STALL_CNT); end
    idle();
  endtask

  task automatic test_drain_halt();
    idle();
    bus.HOLD_REQ = 1'b1;
    #1;
    checks++; if (bus.PC_LE !== 1'b1) begin errors++; $display("FAIL hold_req_run_pc got %0b want 1", bus.PC_LE); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.STATE !== 2'b01) begin errors++; $display("FAIL drain_state[%0d] got %0b want 01", i, bus.STATE); end
      checks++; if (bus.HOLD_ACK !== 1'b0) begin errors++; $display("FAIL drain_ack[%0d] got %0b want 0", i, bus.HOLD_ACK); end
      checks++; if ({bus.PC_LE, bus.IF_ID_LE, bus.NOP_SEL, bus.IF_ID_CLR} !== 4'b0010) begin
        errors++; $display("FAIL drain_freeze[%0d] got %b want 0010", i, {bus.PC_LE, bus.IF_ID_LE, bus.NOP_SEL, bus.IF_ID_CLR});
      end
    end
    step();
    checks++; if (bus.STATE !== 2'b10) begin errors++; $display("FAIL halted_state got %0b want 10", bus.STATE); end
    checks++; if (bus.HOLD_ACK !== 1'b1) begin errors++; $display("FAIL halted_ack got %0b want 1", bus.HOLD_ACK); end
    checks++; if (bus.PC_LE !== 1'b0) begin errors++; $display("FAIL halted_pc got %0b want 0", bus.PC_LE); end
    step();
    checks++; if (bus.STATE !== 2'b10) begin errors++; $display("FAIL halted_hold got %0b want 10", bus.STATE); end
    bus.HOLD_REQ = 1'b0;
    step();
    checks++; if (bus.STATE !== 2'b00) begin errors++; $display("FAIL resume_state got %0b want 00", bus.STATE); end
    checks++; if (bus.HOLD_ACK !== 1'b0) begin errors++; $display("FAIL resume_ack got %0b want 0", bus.HOLD_ACK); end
    checks++; if (bus.PC_LE !== 1'b1) begin errors++; $display("FAIL resume_pc got %0b want 1", bus.PC_LE); end
    // A one-cycle request still completes the full drain.
    bus.HOLD_REQ = 1'b1;
    step();
    bus.HOLD_REQ = 1'b0;
    step(); step();
    checks++; if (bus.STATE !== 2'b01) begin errors++; $display("FAIL noabort_drain got %0b want 01", bus.STATE); end
    step();
    checks++; if (bus.HOLD_ACK !== 1'b1) begin errors++; $display("FAIL noabort_ack got %0b want 1", bus.HOLD_ACK); end
    step();
    checks++; if (bus.STATE !== 2'b00) begin errors++; $display("FAIL noabort_resume got %0b want 00", bus.STATE); end
  endtask

  task automatic test_defer_reset();
    idle();
    bus.HOLD_REQ = 1'b1; bus.EX_BR_TAKEN = 1'b1;
    step();
    checks++; if (bus.STATE !== 2'b00) begin errors++; $display("FAIL defer_state got %0b want 00", bus.STATE); end
    bus.EX_BR_TAKEN = 1'b0;
    step();
    checks++; if (bus.STATE !== 2'b01) begin errors++; $display("FAIL defer_drain got %0b want 01", bus.STATE); end
    step(); step(); step();
    checks++; if (bus.HOLD_ACK !== 1'b1) begin errors++; $display("FAIL defer_ack got %0b want 1", bus.HOLD_ACK); end
    Rst = 1'b1;
    #1;
    checks++; if (bus.IF_ID_CLR !== 1'b1) begin errors++; $display("FAIL rsth_clr got %0b want 1", bus.IF_ID_CLR); end
    step();
    checks++; if (bus.STATE !== 2'b00) begin errors++; $display("FAIL rsth_state got %0b want 00", bus.STATE); end
    checks++; if (bus.HOLD_ACK !== 1'b0) begin errors++; $display("FAIL rsth_ack got %0b want 0", bus.HOLD_ACK); end
    checks++; if (bus.FLUSH_CNT !== 4'd0) begin errors++; $display("FAIL rsth_flush got %0d want 0", bus.FLUSH_CNT); end
    checks++; if (bus.STALL_CNT !== 4'd0) begin errors++; $display("FAIL rsth_stall got %0d want 0", bus.STALL_CNT); end
    Rst = 1'b0;
    idle();
    step();
    checks++; if (bus.STATE !== 2'b00) begin errors++; $display("FAIL post_rst_state got %0b want 00", bus.STATE); end
  endtask

  task automatic test_saturation();
    idle();
    bus.EX_L = 1'b1; bus.EX_RF_LE = 1'b1; bus.EX_RD = 5'd3; bus.ID_RA = 5'd3; bus.ID_USE_RA = 1'b1;
    for (int i = 0; i < 14; i++) step();
    checks++; if (bus.STALL_CNT !== 4'd14) begin errors++; $display("FAIL sat_mid got %0d want 14", bus.STALL_CNT); end
    for (int i = 0; i < 6; i++) step();
    checks++; if (bus.STALL_CNT !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", bus.STALL_CNT); end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Rst = 1'b1;
    idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_drain_halt();
    test_defer_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
